// File: rtl/rt_cmd_pkg.sv
// rt_cmd_pkg: command record layout, host register map and FSM state codes for rt_cmd_queue
package rt_cmd_pkg;
    localparam int CMD_W = 338;

    typedef struct packed {
        logic [47:0] freq;
        logic [47:0] dfreq;
        logic [31:0] rate;
        logic [63:0] tstart;
        logic [15:0] n;
        logic [1:0]  typ;
        logic [31:0] ti;
        logic [31:0] tp;
        logic [31:0] tb1;
        logic [31:0] tb2;
    } cmd_t;

    localparam logic [3:0] A_FREQ_LO  = 4'd0;
    localparam logic [3:0] A_FREQ_HI  = 4'd1;
    localparam logic [3:0] A_DFREQ_LO = 4'd2;
    localparam logic [3:0] A_DFREQ_HI = 4'd3;
    localparam logic [3:0] A_RATE     = 4'd4;
    localparam logic [3:0] A_TS_LO    = 4'd5;
    localparam logic [3:0] A_TS_HI    = 4'd6;
    localparam logic [3:0] A_TYPE_N   = 4'd7;
    localparam logic [3:0] A_TI       = 4'd8;
    localparam logic [3:0] A_TP       = 4'd9;
    localparam logic [3:0] A_TB1      = 4'd10;
    localparam logic [3:0] A_TB2      = 4'd11;
    localparam logic [3:0] A_FLUSH    = 4'd14;
    localparam logic [3:0] A_COMMIT   = 4'd15;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_ARMED = 3'd4;
    localparam logic [2:0] S_RUN   = 3'd5;
endpackage

// File: rtl/cmd_fifo_ram.sv
// cmd_fifo_ram: simple dual-port command storage with registered read
module cmd_fifo_ram
    import rt_cmd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  cmd_t                     i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output cmd_t                     o_rdata
);
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [CMD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/rt_cmd_queue.sv
// rt_cmd_queue: host-loaded command FIFO that arms master_start one command at a time
module rt_cmd_queue
    import rt_cmd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int GUARD = 48
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_host_wr,
    input  logic [3:0]             i_host_addr,
    input  logic [31:0]            i_host_data,
    input  logic [63:0]            i_time,
    input  logic                   i_req_command,
    output logic                   o_wr_data,
    output logic [47:0]            o_mem_dds_freq,
    output logic [47:0]            o_mem_dds_delta_freq,
    output logic [31:0]            o_mem_dds_delta_rate,
    output logic [63:0]            o_mem_time_start,
    output logic [15:0]            o_mem_n_impuls,
    output logic [1:0]             o_mem_type_impulse,
    output logic [31:0]            o_mem_interval_ti,
    output logic [31:0]            o_mem_interval_tp,
    output logic [31:0]            o_mem_tblank1,
    output logic [31:0]            o_mem_tblank2,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty,
    output logic                   o_overflow,
    output logic [15:0]            o_late_cnt,
    output logic                   o_busy
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          r_stage, r_mem, w_rd;
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [2:0]    r_state;
    logic [15:0]   r_late;
    logic          r_commit, r_wr_data, r_overflow;
    logic          r_req_s1, r_req_s2, r_req_d;
    logic          w_flush, w_push, w_pop, w_rise, w_fall, w_ontime, w_disarm;

    assign w_flush  = i_host_wr && i_host_addr == A_FLUSH;
    assign w_push   = r_commit && !o_full && !w_flush;
    assign w_pop    = r_state == S_READ;
    assign w_rise   = r_req_s2 && !r_req_d;
    assign w_fall   = !r_req_s2 && r_req_d;
    assign w_ontime = w_rd.tstart > i_time + 64'(GUARD);
    assign w_disarm = w_flush && (r_state == S_ISSUE || r_state == S_ARMED);

    cmd_fifo_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk  (i_clk),
        .i_we   (w_push),
        .i_waddr(r_wptr),
        .i_wdata(r_stage),
        .i_re   (w_pop),
        .i_raddr(r_rptr),
        .o_rdata(w_rd)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stage <= '0;
        end else if (i_host_wr) begin
            case (i_host_addr)
                A_FREQ_LO:  r_stage.freq[31:0]   <= i_host_data;
                A_FREQ_HI:  r_stage.freq[47:32]  <= i_host_data[15:0];
                A_DFREQ_LO: r_stage.dfreq[31:0]  <= i_host_data;
                A_DFREQ_HI: r_stage.dfreq[47:32] <= i_host_data[15:0];
                A_RATE:     r_stage.rate         <= i_host_data;
                A_TS_LO:    r_stage.tstart[31:0] <= i_host_data;
                A_TS_HI:    r_stage.tstart[63:32] <= i_host_data;
                A_TYPE_N:   {r_stage.typ, r_stage.n} <= i_host_data[17:0];
                A_TI:       r_stage.ti  <= i_host_data;
                A_TP:       r_stage.tp  <= i_host_data;
                A_TB1:      r_stage.tb1 <= i_host_data;
                A_TB2:      r_stage.tb2 <= i_host_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        r_commit <= !i_reset && i_host_wr && i_host_addr == A_COMMIT;
        if (i_reset || w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wptr     <= w_push ? r_wptr + 1'b1 : r_wptr;
            r_rptr     <= w_pop ? r_rptr + 1'b1 : r_rptr;
            r_count    <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            r_overflow <= r_overflow || (r_commit && o_full);
        end
    end

    // Two flops resynchronise REQ_COMMAND; the third holds its previous value for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_req_d  <= 1'b0;
        end else begin
            r_req_s1 <= i_req_command;
            r_req_s2 <= r_req_s1;
            r_req_d  <= r_req_s2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_wr_data      <= 1'b0;
            r_late         <= '0;
            r_mem          <= '0;
            r_mem.tstart   <= '1;
        end else begin
            r_wr_data <= 1'b0;
            if (w_flush) r_late <= '0;
            if (w_disarm) begin
                r_mem.tstart <= '1;
                r_wr_data    <= 1'b1;
                r_state      <= S_IDLE;
            end else if (w_flush && r_state != S_RUN) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE:  r_state <= o_empty ? S_IDLE : S_READ;
                    S_READ:  r_state <= S_CHECK;
                    S_CHECK: begin
                        if (w_ontime) begin
                            r_mem     <= w_rd;
                            r_wr_data <= 1'b1;
                            r_state   <= S_ISSUE;
                        end else begin
                            r_late  <= r_late + 16'(r_late != 16'hFFFF);
                            r_state <= S_IDLE;
                        end
                    end
                    S_ISSUE: r_state <= S_ARMED;
                    S_ARMED: r_state <= w_rise ? S_RUN : S_ARMED;
                    S_RUN:   r_state <= w_fall ? S_IDLE : S_RUN;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_wr_data            = r_wr_data;
    assign o_mem_dds_freq       = r_mem.freq;
    assign o_mem_dds_delta_freq = r_mem.dfreq;
    assign o_mem_dds_delta_rate = r_mem.rate;
    assign o_mem_time_start     = r_mem.tstart;
    assign o_mem_n_impuls       = r_mem.n;
    assign o_mem_type_impulse   = r_mem.typ;
    assign o_mem_interval_ti    = r_mem.ti;
    assign o_mem_interval_tp    = r_mem.tp;
    assign o_mem_tblank1        = r_mem.tb1;
    assign o_mem_tblank2        = r_mem.tb2;
    assign o_count              = r_count;
    assign o_full               = r_count == (AW+1)'(DEPTH);
    assign o_empty              = r_count == '0;
    assign o_overflow           = r_overflow;
    assign o_late_cnt           = r_late;
    assign o_busy               = r_state == S_ARMED || r_state == S_RUN;
endmodule
